// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, 8N1 by default. Parity
// (odd/even) and a second stop bit are optional. A one-byte holding register
// behind a valid/ready handshake lets frames run back to back with no idle gap.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   i_tx_data   byte to send, sampled when i_tx_valid && o_tx_ready
//   i_tx_valid  i_tx_data is valid
//   o_tx_ready  holding register empty (registered)
//   o_tx        serial line, idle high, driven straight from a flop
//   o_tx_busy   holding register full or a frame in progress (registered)
module uart_tx #(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx,
  output logic       o_tx_busy
);

  localparam int NCLKS_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int CNT_W = (NCLKS_PER_BIT >= 2) ? $clog2(NCLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(NCLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  generate
    if (NCLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_RATE/BAUD_RATE must be at least 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a byte: even parity makes the total number of ones even.
  function automatic logic parity_bit(input logic [7:0] data);
    logic bit_s;
    if (PARITY == 2) begin
      bit_s = ^data;
    end else begin
      bit_s = ~^data;
    end
    return bit_s;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       shifter_r, shifter_s;
  logic             parity_r, parity_s;
  logic [7:0]       hold_data_r, hold_data_s;
  logic             hold_valid_r, hold_valid_s;
  logic             tx_r, tx_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             baud_done_s;
  logic             load_s;
  logic             accept_s;

  assign baud_done_s = (baud_cnt_r == BAUD_LAST);
  assign accept_s    = i_tx_valid && ready_r;

  // Next-state, counters, holding register and next line level.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shifter_s    = shifter_r;
    parity_s     = parity_r;
    hold_data_s  = hold_data_r;
    hold_valid_s = hold_valid_r;
    load_s       = 1'b0;
    tx_s         = 1'b1;

    // The baud counter only runs inside a frame and restarts on every bit edge.
    if ((state_r == S_IDLE) || baud_done_s) begin
      baud_cnt_s = '0;
    end else begin
      baud_cnt_s = baud_cnt_r + CNT_W'(1);
    end

    case (state_r)
      S_IDLE: begin
        bit_cnt_s = 3'd0;
        if (hold_valid_r) begin
          load_s  = 1'b1;
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          state_s = S_DATA;
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          shifter_s = {1'b0, shifter_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            bit_cnt_s = 3'd0;
            state_s   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (baud_done_s) begin
          state_s = S_STOP;
        end else begin
          state_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (baud_done_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            bit_cnt_s = 3'd0;
            // A waiting byte starts immediately: no idle cycle between frames.
            if (hold_valid_r) begin
              load_s  = 1'b1;
              state_s = S_START;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      default: begin
        state_s   = S_IDLE;
        bit_cnt_s = 3'd0;
      end
    endcase

    // Load and accept never coincide: a load needs hold_valid, which holds ready low.
    if (load_s) begin
      shifter_s    = hold_data_r;
      parity_s     = parity_bit(hold_data_r);
      hold_valid_s = 1'b0;
    end else if (accept_s) begin
      hold_data_s  = i_tx_data;
      hold_valid_s = 1'b1;
    end else begin
      hold_valid_s = hold_valid_r;
    end

    // The line level follows the state being entered so o_tx can be a flop.
    case (state_s)
      S_IDLE:   tx_s = 1'b1;
      S_START:  tx_s = 1'b0;
      S_DATA:   tx_s = shifter_s[0];
      S_PARITY: tx_s = parity_s;
      S_STOP:   tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase

    ready_s = !hold_valid_s;
    busy_s  = hold_valid_s || (state_s != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      baud_cnt_r   <= '0;
      bit_cnt_r    <= 3'd0;
      shifter_r    <= 8'h00;
      parity_r     <= 1'b0;
      hold_data_r  <= 8'h00;
      hold_valid_r <= 1'b0;
      tx_r         <= 1'b1;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      baud_cnt_r   <= baud_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      shifter_r    <= shifter_s;
      parity_r     <= parity_s;
      hold_data_r  <= hold_data_s;
      hold_valid_r <= hold_valid_s;
      tx_r         <= tx_s;
      ready_r      <= ready_s;
      busy_r       <= busy_s;
    end
  end

  assign o_tx       = tx_r;
  assign o_tx_ready = ready_r;
  assign o_tx_busy  = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx. Three instances at
// 10 clocks per bit: 8N1 (a), even parity + 2 stop (b), odd parity + 2 stop (c).
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;

  int vectors;
  int miscompares;

  uart_tx #(.CLK_RATE(100_000_000), .BAUD_RATE(10_000_000), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .i_tx_data(data_a), .i_tx_valid(valid_a),
    .o_tx_ready(ready_a), .o_tx(tx_a), .o_tx_busy(busy_a)
  );

  uart_tx #(.CLK_RATE(100_000_000), .BAUD_RATE(10_000_000), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .i_tx_data(data_b), .i_tx_valid(valid_b),
    .o_tx_ready(ready_b), .o_tx(tx_b), .o_tx_busy(busy_b)
  );

  uart_tx #(.CLK_RATE(100_000_000), .BAUD_RATE(10_000_000), .PARITY(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .i_tx_data(data_c), .i_tx_valid(valid_c),
    .o_tx_ready(ready_c), .o_tx(tx_c), .o_tx_busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_a = 1'b1; data_a = 8'h55;
    valid_b = 1'b1; data_b = 8'h55;
    valid_c = 1'b1; data_c = 8'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 ||
          tx_b !== 1'b1 || busy_b !== 1'b0 || tx_c !== 1'b1 || busy_c !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: tx=%b%b%b ready=%b busy=%b%b%b, expected tx=111 ready=1 busy=000",
                 i, tx_a, tx_b, tx_c, ready_a, busy_a, busy_b, busy_c);
      end
    end
    rst = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    tick();
    tick();
    vectors++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: tx=%b ready=%b busy=%b, expected 1 1 0", tx_a, ready_a, busy_a);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    data_a = 8'hA5;
    valid_a = 1'b1;
    tick();  // acceptance edge
    valid_a = 1'b0;
    vectors++;
    if (tx_a !== 1'b1 || ready_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_accept: tx=%b ready=%b busy=%b, expected 1 0 1", tx_a, ready_a, busy_a);
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      vectors++;
      if (tx_a !== frame[c / 10] || busy_a !== 1'b1 || ready_a !== 1'b1) begin
        miscompares++;
        $display("FAIL single_frame c=%0d: tx=%b busy=%b ready=%b, expected tx=%b busy=1 ready=1",
                 c, tx_a, busy_a, ready_a, frame[c / 10]);
      end
    end
    tick();
    vectors++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_end: tx=%b busy=%b ready=%b, expected 1 0 1", tx_a, busy_a, ready_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1;
    logic [9:0] f2;
    logic       exp_tx;
    logic       exp_ready;
    logic       exp_busy;
    f1 = {1'b1, 8'h00, 1'b0};
    f2 = {1'b1, 8'hFF, 1'b0};
    data_a = 8'h00;
    valid_a = 1'b1;
    tick();  // accept 0x00
    vectors++;
    if (ready_a !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept1: ready=%b, expected 0", ready_a);
    end
    data_a = 8'hFF;
    tick();  // first byte loads (c = 0)
    vectors++;
    if (tx_a !== 1'b0 || ready_a !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_load1: tx=%b ready=%b, expected 0 1", tx_a, ready_a);
    end
    tick();  // accept 0xFF (c = 1)
    valid_a = 1'b0;
    vectors++;
    if (ready_a !== 1'b0 || tx_a !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept2: ready=%b tx=%b, expected 0 0", ready_a, tx_a);
    end
    for (int c = 2; c <= 200; c++) begin
      tick();
      if (c < 100) begin
        exp_tx = f1[c / 10]; exp_ready = 1'b0; exp_busy = 1'b1;
      end else if (c < 200) begin
        exp_tx = f2[(c - 100) / 10]; exp_ready = 1'b1; exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1; exp_ready = 1'b1; exp_busy = 1'b0;
      end
      vectors++;
      if (tx_a !== exp_tx || ready_a !== exp_ready || busy_a !== exp_busy) begin
        miscompares++;
        $display("FAIL b2b_frame c=%0d: tx=%b ready=%b busy=%b, expected %b %b %b",
                 c, tx_a, ready_a, busy_a, exp_tx, exp_ready, exp_busy);
      end
    end
  endtask

  task automatic test_parity();
    logic [11:0] fb;
    logic [11:0] fc;
    fb = {2'b11, 1'b1, 8'h07, 1'b0};  // even: three ones -> parity 1
    fc = {2'b11, 1'b0, 8'h07, 1'b0};  // odd: three ones -> parity 0
    data_b = 8'h07; valid_b = 1'b1;
    data_c = 8'h07; valid_c = 1'b1;
    tick();
    valid_b = 1'b0; valid_c = 1'b0;
    for (int c = 0; c < 120; c++) begin
      tick();
      vectors++;
      if (tx_b !== fb[c / 10] || tx_c !== fc[c / 10] || busy_b !== 1'b1 || busy_c !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_frame c=%0d: tx_even=%b tx_odd=%b busy=%b%b, expected %b %b busy=11",
                 c, tx_b, tx_c, busy_b, busy_c, fb[c / 10], fc[c / 10]);
      end
    end
    tick();
    vectors++;
    if (busy_b !== 1'b0 || busy_c !== 1'b0 || tx_b !== 1'b1 || tx_c !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_end: busy=%b%b tx=%b%b, expected busy=00 tx=11", busy_b, busy_c, tx_b, tx_c);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f1;
    logic [9:0] f2;
    logic       idle_ok;
    f1 = {1'b1, 8'h5A, 1'b0};
    f2 = {1'b1, 8'h3C, 1'b0};
    data_a = 8'h5A; valid_a = 1'b1;
    tick();               // accept 0x5A
    data_a = 8'h3C;
    tick();               // load 0x5A, c = 0
    tick();               // accept 0x3C into holding register, c = 1
    valid_a = 1'b0;
    for (int c = 2; c <= 44; c++) begin
      tick();
      vectors++;
      if (tx_a !== f1[c / 10]) begin
        miscompares++;
        $display("FAIL midrst_frame c=%0d: tx=%b, expected %b", c, tx_a, f1[c / 10]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_abort: tx=%b ready=%b busy=%b, expected 1 1 0", tx_a, ready_a, busy_a);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_ok = 1'b0;
    end
    vectors++;
    if (idle_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_discard: line left idle or busy raised after reset, got %b, expected 1", idle_ok);
    end
    data_a = 8'h3C; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int c = 0; c < 101; c++) begin
      tick();
      vectors++;
      if (c < 100 && tx_a !== f2[c / 10]) begin
        miscompares++;
        $display("FAIL midrst_resend c=%0d: tx=%b, expected %b", c, tx_a, f2[c / 10]);
      end else if (c == 100 && (tx_a !== 1'b1 || busy_a !== 1'b0)) begin
        miscompares++;
        $display("FAIL midrst_resend_end: tx=%b busy=%b, expected 1 0", tx_a, busy_a);
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [8];
    logic [7:0] rx_byte;
    logic       accept;
    logic       rx_active;
    logic       idle_ok;
    int         sent;
    int         got;
    int         rx_c;
    int         cyc;
    bytes = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h55, 8'hAA};
    sent = 0; got = 0; rx_c = 0; cyc = 0;
    rx_active = 1'b0; rx_byte = 8'h00;
    data_a = bytes[0]; valid_a = 1'b1;
    while (got < 8 && cyc < 2000) begin
      accept = valid_a && ready_a;
      tick();
      cyc++;
      if (accept) begin
        sent++;
        if (sent < 8) data_a = bytes[sent];
        else valid_a = 1'b0;
      end
      // Simple receiver: detect start, sample each bit at its middle cycle.
      if (!rx_active) begin
        if (tx_a === 1'b0) begin
          rx_active = 1'b1;
          rx_c = 0;
        end
      end else begin
        rx_c++;
        if (rx_c >= 15 && rx_c <= 85 && (rx_c % 10) == 5) begin
          rx_byte = {tx_a, rx_byte[7:1]};
        end else if (rx_c == 95) begin
          vectors++;
          if (tx_a !== 1'b1 || rx_byte !== bytes[got]) begin
            miscompares++;
            $display("FAIL loopback byte %0d: got %h stop=%b, expected %h stop=1", got, rx_byte, tx_a, bytes[got]);
          end
          got++;
          rx_active = 1'b0;
        end
      end
    end
    valid_a = 1'b0;
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL loopback_count: received %0d bytes in %0d cycles, expected 8", got, cyc);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx_a !== 1'b1) idle_ok = 1'b0;
    end
    vectors++;
    if (idle_ok !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL loopback_extra: idle=%b busy=%b, expected 1 0", idle_ok, busy_a);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
